// File: rtl/pixmem_arbiter.sv
// Dual-bank pixel memory arbiter: video reads win, the GoL engine takes the rest.
// Optional one-word video pixel cache enabled by defining PIXEL_CACHE_EN.
module pixmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int PIX_W  = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [SEL_W-1:0]  vid_pix_sel,
  output logic [PIX_W-1:0]  vid_pixel,
  input  logic              frame_end,
  input  logic              eng_valid,
  output logic              eng_ready,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [31:0]       eng_wdata,
  input  logic [7:0]        eng_wmask,
  output logic [31:0]       eng_rdata,
  output logic              eng_rvalid,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              disp_bank,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             disp_q, ack_q;
  logic             act_q, miss_q, rd_q;
  logic [SEL_W-1:0] sel_q;
  logic [PIX_W-1:0] pix_q;
  logic [31:0]      rdata_q;
  logic             swap_cycle, vid_miss, eng_acc;
  logic [31:0]      word;

  assign swap_cycle = frame_end & ((state_q == S_PEND) | swap_req);

`ifdef PIXEL_CACHE_EN
  logic [31:0]       cache_q;
  logic [ADDR_W-1:0] tag_q;
  logic              cval_q;

  assign vid_miss = !reset & vid_active & (!cval_q | (vid_addr != tag_q));
  assign word     = miss_q ? mem_rdata : cache_q;

  // A miss coinciding with a swap fills from the old bank, so it stays invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_q <= '0;
      tag_q   <= '0;
      cval_q  <= 1'b0;
    end else begin
      if (miss_q) cache_q <= mem_rdata;
      if (vid_miss) tag_q <= vid_addr;
      if (swap_cycle) cval_q <= 1'b0;
      else if (vid_miss) cval_q <= 1'b1;
    end
  end
`else
  assign vid_miss = !reset & vid_active;
  assign word     = mem_rdata;
`endif

  assign eng_ready = !reset & !vid_miss & !swap_cycle;
  assign eng_acc   = eng_valid & eng_ready;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_bank  = disp_q;
    mem_addr  = vid_addr;
    mem_wmask = '0;
    mem_wdata = '0;
    unique case (1'b1)
      vid_miss: mem_en = 1'b1;
      eng_acc: begin
        mem_en   = 1'b1;
        mem_we   = eng_we;
        mem_bank = eng_we ? ~disp_q : disp_q;
        mem_addr = eng_addr;
        if (eng_we) begin
          mem_wmask = eng_wmask;
          mem_wdata = eng_wdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (swap_cycle) state_d = S_IDLE;
    else if (swap_req) state_d = S_PEND;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      disp_q  <= 1'b0;
      ack_q   <= 1'b0;
      act_q   <= 1'b0;
      miss_q  <= 1'b0;
      sel_q   <= '0;
      pix_q   <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= swap_cycle;
      if (swap_cycle) disp_q <= ~disp_q;
      act_q   <= vid_active;
      miss_q  <= vid_miss;
      sel_q   <= vid_pix_sel;
      pix_q   <= act_q ? word[sel_q*PIX_W +: PIX_W] : '0;
      rd_q    <= eng_acc & !eng_we;
      if (rd_q) rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) eng_rvalid <= 1'b0;
    else eng_rvalid <= rd_q;
  end

  assign vid_pixel = pix_q;
  assign eng_rdata = rdata_q;
  assign swap_ack  = ack_q;
  assign disp_bank = disp_q;

endmodule

// File: tb/tb_pixmem_arbiter.sv
// Directed testbench for pixmem_arbiter with a two-bank memory model.
// Expectations adapt to the PIXEL_CACHE_EN build option.
module tb_pixmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        vid_active;
  logic [8:0]  vid_addr;
  logic [2:0]  vid_pix_sel;
  logic [3:0]  vid_pixel;
  logic        frame_end;
  logic        eng_valid, eng_ready, eng_we;
  logic [8:0]  eng_addr;
  logic [31:0] eng_wdata, eng_rdata;
  logic [7:0]  eng_wmask;
  logic        eng_rvalid, swap_req, swap_ack, disp_bank;
  logic        mem_en, mem_we, mem_bank;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] b0 [512];
  logic [31:0] b1 [512];
  logic        ld_en = 1'b0, ld_bank;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  int          rd_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pixmem_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_active(vid_active), .vid_addr(vid_addr),
    .vid_pix_sel(vid_pix_sel), .vid_pixel(vid_pixel),
    .frame_end(frame_end),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_wmask(eng_wmask),
    .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .swap_req(swap_req), .swap_ack(swap_ack), .disp_bank(disp_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_bank(mem_bank),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_bank) b1[ld_addr] <= ld_data;
      else b0[ld_addr] <= ld_data;
    end else if (mem_en && !reset) begin
      if (mem_we) begin
        for (int k = 0; k < 8; k++)
          if (mem_wmask[k]) begin
            if (mem_bank) b1[mem_addr][k*4 +: 4] <= mem_wdata[k*4 +: 4];
            else b0[mem_addr][k*4 +: 4] <= mem_wdata[k*4 +: 4];
          end
      end else begin
        mem_rdata <= mem_bank ? b1[mem_addr] : b0[mem_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic bk, input logic [8:0] a,
                         input logic [31:0] d);
    ld_en = 1'b1; ld_bank = bk; ld_addr = a; ld_data = d;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic test_eng_read();
    cyc();
    eng_valid = 1'b1; eng_we = 1'b0; eng_addr = 9'd7;
    #1;
    checks++;
    if (eng_ready !== 1'b1 || mem_en !== 1'b1 || mem_bank !== 1'b0)
      begin errors++;
      $display("FAIL eng_read_issue ready=%b en=%b bank=%b want 1 1 0",
               eng_ready, mem_en, mem_bank); end
    cyc();
    eng_valid = 1'b0;
    #1;
    checks++;
    if (eng_rvalid !== 1'b0) begin errors++;
      $display("FAIL eng_read_early rvalid=%b want 0", eng_rvalid); end
    cyc();
    checks++;
    if (eng_rvalid !== 1'b1 || eng_rdata !== 32'h12345678) begin errors++;
      $display("FAIL eng_read_data rvalid=%b data=%h want 1 12345678",
               eng_rvalid, eng_rdata); end
    cyc();
    checks++;
    if (eng_rvalid !== 1'b0) begin errors++;
      $display("FAIL eng_read_pulse rvalid=%b want 0", eng_rvalid); end
  endtask

  task automatic test_reset();
    cyc();
    eng_valid = 1'b1; eng_we = 1'b0; eng_addr = 9'd7;
    cyc();
    eng_valid = 1'b0;
    vid_active = 1'b1; vid_addr = 9'd9;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || vid_pixel !== 4'h0 || eng_rvalid !== 1'b0 ||
        eng_rdata !== 32'h0 || swap_ack !== 1'b0 || disp_bank !== 1'b0)
      begin errors++;
      $display("FAIL reset_async en=%b pix=%h rv=%b rd=%h ack=%b db=%b want all 0",
               mem_en, vid_pixel, eng_rvalid, eng_rdata, swap_ack, disp_bank); end
    cyc();
    reset = 1'b0;
    vid_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (eng_rvalid !== 1'b0) begin errors++;
        $display("FAIL reset_inflight cyc=%0d rvalid=%b want 0", i, eng_rvalid); end
    end
  endtask

  task automatic test_video_stream();
    int base;
    logic exp_rdy;
    cyc();
    base = rd_cnt;
    for (int i = 0; i < 12; i++) begin
      vid_active = (i < 8);
      vid_addr = 9'd5;
      vid_pix_sel = i[2:0];
      #1;
`ifdef PIXEL_CACHE_EN
      exp_rdy = (i != 0);
`else
      exp_rdy = (i >= 8);
`endif
      checks++;
      if (eng_ready !== exp_rdy) begin errors++;
        $display("FAIL vid_ready cyc=%0d got %b want %b", i, eng_ready, exp_rdy); end
      if (i >= 2) begin
        checks++;
        if (vid_pixel !== ((i - 2 < 8) ? 4'(i - 2) : 4'h0)) begin errors++;
          $display("FAIL vid_pixel cyc=%0d got %h want %h", i, vid_pixel,
                   (i - 2 < 8) ? 4'(i - 2) : 4'h0); end
      end
      cyc();
    end
    checks++;
`ifdef PIXEL_CACHE_EN
    if (rd_cnt - base !== 1) begin errors++;
      $display("FAIL vid_reads got %0d want 1", rd_cnt - base); end
`else
    if (rd_cnt - base !== 8) begin errors++;
      $display("FAIL vid_reads got %0d want 8", rd_cnt - base); end
`endif
  endtask

  task automatic test_eng_write_held();
    cyc();
    vid_active = 1'b1; vid_addr = 9'd20; vid_pix_sel = 3'd0;
    eng_valid = 1'b1; eng_we = 1'b1; eng_addr = 9'd3;
    eng_wdata = 32'hDEADBEEF; eng_wmask = 8'h0F;
    #1;
    checks++;
    if (eng_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 9'd20)
      begin errors++;
      $display("FAIL wr_held ready=%b we=%b addr=%0d want 0 0 20",
               eng_ready, mem_we, mem_addr); end
    cyc();
    vid_active = 1'b0;
    #1;
    checks++;
    if (eng_ready !== 1'b1 || mem_we !== 1'b1 || mem_bank !== 1'b1 ||
        mem_wmask !== 8'h0F || mem_addr !== 9'd3 || mem_wdata !== 32'hDEADBEEF)
      begin errors++;
      $display("FAIL wr_issue rdy=%b we=%b bank=%b mask=%h addr=%0d data=%h want 1 1 1 0f 3 deadbeef",
               eng_ready, mem_we, mem_bank, mem_wmask, mem_addr, mem_wdata); end
    cyc();
    eng_valid = 1'b0;
    #1;
    checks++;
    if (vid_pixel !== 4'hC || b1[3] !== 32'h0000BEEF) begin errors++;
      $display("FAIL wr_result pix=%h mem=%h want c 0000beef", vid_pixel, b1[3]); end
  endtask

  task automatic test_swap();
    cyc();
    swap_req = 1'b1;
    #1;
    checks++;
    if (eng_ready !== 1'b1) begin errors++;
      $display("FAIL swap_req_ready got %b want 1", eng_ready); end
    cyc();
    swap_req = 1'b0;
    repeat (99) cyc();
    checks++;
    if (disp_bank !== 1'b0 || swap_ack !== 1'b0) begin errors++;
      $display("FAIL swap_early db=%b ack=%b want 0 0", disp_bank, swap_ack); end
    frame_end = 1'b1;
    eng_valid = 1'b1; eng_we = 1'b1; eng_addr = 9'd4;
    eng_wdata = 32'h11111111; eng_wmask = 8'hFF;
    #1;
    checks++;
    if (eng_ready !== 1'b0 || mem_en !== 1'b0) begin errors++;
      $display("FAIL swap_cycle ready=%b en=%b want 0 0", eng_ready, mem_en); end
    cyc();
    frame_end = 1'b0;
    #1;
    checks++;
    if (swap_ack !== 1'b1 || disp_bank !== 1'b1 || eng_ready !== 1'b1 ||
        mem_we !== 1'b1 || mem_bank !== 1'b0) begin errors++;
      $display("FAIL swap_done ack=%b db=%b rdy=%b we=%b bank=%b want 1 1 1 1 0",
               swap_ack, disp_bank, eng_ready, mem_we, mem_bank); end
    cyc();
    eng_valid = 1'b0;
    vid_active = 1'b1; vid_addr = 9'd20; vid_pix_sel = 3'd0;
    #1;
    checks++;
    if (swap_ack !== 1'b0 || mem_en !== 1'b1 || mem_bank !== 1'b1 ||
        mem_we !== 1'b0) begin errors++;
      $display("FAIL swap_vid ack=%b en=%b bank=%b we=%b want 0 1 1 0",
               swap_ack, mem_en, mem_bank, mem_we); end
    cyc();
    vid_active = 1'b0;
  endtask

  task automatic test_swap_reset();
    cyc();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (2) cyc();
    frame_end = 1'b1;
    #1;
    checks++;
    if (eng_ready !== 1'b1) begin errors++;
      $display("FAIL swap_rst_ready got %b want 1", eng_ready); end
    cyc();
    frame_end = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (swap_ack !== 1'b0 || disp_bank !== 1'b0) begin errors++;
        $display("FAIL swap_rst cyc=%0d ack=%b db=%b want 0 0",
                 i, swap_ack, disp_bank); end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    vid_active = 1'b0; vid_addr = '0; vid_pix_sel = '0;
    frame_end = 1'b0; swap_req = 1'b0;
    eng_valid = 1'b0; eng_we = 1'b0; eng_addr = '0;
    eng_wdata = '0; eng_wmask = '0;
    preload(1'b0, 9'd5, 32'h76543210);
    preload(1'b0, 9'd7, 32'h12345678);
    preload(1'b0, 9'd20, 32'h0000000C);
    preload(1'b1, 9'd3, 32'h00000000);
    #1;
    checks++;
    if (vid_pixel !== 4'h0 || eng_rvalid !== 1'b0 || swap_ack !== 1'b0 ||
        disp_bank !== 1'b0 || mem_en !== 1'b0) begin errors++;
      $display("FAIL reset_state pix=%h rv=%b ack=%b db=%b en=%b want all 0",
               vid_pixel, eng_rvalid, swap_ack, disp_bank, mem_en); end
    cyc();
    reset = 1'b0;
    test_eng_read();
    test_reset();
    test_video_stream();
    test_eng_write_held();
    test_swap();
    test_swap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
